// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between mem_port_arbiter and its environment.
// Carries the fetch port, the data port, the stalls/err and the memory port.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;

  logic              dm_req;
  logic              dm_we;
  logic [BE_W-1:0]   dm_be;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;

  logic              stall_if;
  logic              stall_mem;
  logic              err;

  logic              mem_req;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_valid,
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output dm_rdata, dm_valid,
    output stall_if, stall_mem, err,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_valid,
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  dm_rdata, dm_valid,
    input  stall_if, stall_mem, err,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data stages.
// Ports: clk, reset (async, active-low), bus (slave side of
// mem_port_arbiter_if: if_*, dm_*, stall_*, err, mem_*).
// Optional MEM_ARB_RR_EN: round-robin between fetch and data
// instead of fixed data-first priority.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = (TIMEOUT_CYCLES > 0) ?
                                 $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_D,
    SERVE_I
  } state_t;

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              dm_valid_q, dm_valid_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic d_elig;
  logic i_elig;
  logic grant_d;
  logic expire;

`ifdef MEM_ARB_RR_EN
  // 1 = data was granted last, 0 = fetch
  logic last_d_q, last_d_d;
`endif

  // A requester whose valid is high is being released this cycle;
  // its still-high req must not start a duplicate access.
  assign d_elig = bus.dm_req & ~dm_valid_q;
  assign i_elig = bus.if_req & ~if_valid_q;

`ifdef MEM_ARB_RR_EN
  assign grant_d = d_elig & (~i_elig | ~last_d_q);
`else
  assign grant_d = d_elig;
`endif

  // mem_ready is checked first, so a same-cycle ready beats expiry.
  assign expire = (TIMEOUT_CYCLES > 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    err_d       = 1'b0;
    cnt_d       = cnt_q;
`ifdef MEM_ARB_RR_EN
    last_d_d    = last_d_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d     = SERVE_D;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.dm_we;
          mem_be_d    = bus.dm_be;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
          cnt_d       = '0;
`ifdef MEM_ARB_RR_EN
          last_d_d    = 1'b1;
`endif
        end else if (i_elig) begin
          state_d     = SERVE_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_be_d    = '1;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
          cnt_d       = '0;
`ifdef MEM_ARB_RR_EN
          last_d_d    = 1'b0;
`endif
        end
      end
      SERVE_D: begin
        if (bus.mem_ready) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          dm_valid_d = 1'b1;
          if (!mem_we_q)
            dm_rdata_d = bus.mem_rdata;
        end else if (expire) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          dm_valid_d = 1'b1;
          err_d      = 1'b1;
          dm_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SERVE_I: begin
        if (bus.mem_ready) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          if_valid_d = 1'b1;
          if_rdata_d = bus.mem_rdata;
        end else if (expire) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          if_valid_d = 1'b1;
          err_d      = 1'b1;
          if_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
`ifdef MEM_ARB_RR_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
`ifdef MEM_ARB_RR_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.dm_valid  = dm_valid_q;
  assign bus.err       = err_q;
  assign bus.stall_if  = bus.if_req & ~if_valid_q;
  assign bus.stall_mem = bus.dm_req & ~dm_valid_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases, then
// random traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam logic [31:0] K = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 30)
        $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_be     = '0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
  endtask

  task automatic do_reset;
    quiet();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
  endtask

  // directed-test scratch
  int nreq, dvc, ivc, ns, nm, nv, ne, first;
  logic pm, errv;
  logic [31:0] rd;

  // reference model state
  logic [31:0] mm [16];
  bit ip, dp;
  logic [31:0] ia, da, dwd;
  logic dwe;
  logic [3:0] dbe;
  bit busy, who_d, hang, pick_d, rdy;
  int waits;
  logic [31:0] g_addr, g_wd;
  logic g_we;
  logic [3:0] g_be;
  bit xi_v, xd_v, x_err, x_mreq;
  bit ni, nd, nerr, ei, ed;
  logic [31:0] x_ir, x_dr;
`ifdef MEM_ARB_RR_EN
  bit last_d;
`endif

  initial begin
    do_reset();

    // reset state
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_flags",
          {bus.if_valid, bus.dm_valid, bus.err, bus.mem_we, bus.mem_be}, 0);
    check("rst_rdata", {bus.if_rdata, bus.dm_rdata}, 0);
    check("rst_mem_bus", {bus.mem_addr, bus.mem_wdata}, 0);
    check("rst_stall", {bus.stall_if, bus.stall_mem}, 0);

    // zero-wait fetch
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    #1;
    check("zf_stall_c1", bus.stall_if, 1'b1);
    tick();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0051_0513;
    #1;
    check("zf_mem_req", bus.mem_req, 1'b1);
    check("zf_mem_addr", bus.mem_addr, 32'h10);
    check("zf_mem_ctl", {bus.mem_we, bus.mem_be}, {1'b0, 4'hf});
    check("zf_stall_c2", bus.stall_if, 1'b1);
    check("zf_valid_c2", bus.if_valid, 1'b0);
    tick();
    check("zf_valid_c3", bus.if_valid, 1'b1);
    check("zf_rdata", bus.if_rdata, 32'h0051_0513);
    check("zf_stall_c3", bus.stall_if, 1'b0);
    bus.if_req    = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
    check("zf_pulse", {bus.if_valid, bus.mem_req}, 0);

    // simultaneous requests: data first, fetch back-to-back
    bus.dm_req    = 1'b1;
    bus.dm_we     = 1'b0;
    bus.dm_be     = 4'hf;
    bus.dm_addr   = 32'h100;
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h20;
    bus.mem_ready = 1'b1;
    nreq = 0; pm = 1'b0; dvc = 0; ivc = 0;
    for (int c = 2; c <= 10; c++) begin
      tick();
      if (bus.mem_req && !pm) nreq++;
      pm = bus.mem_req;
      if (bus.dm_valid) begin dvc = c; bus.dm_req = 1'b0; end
      if (bus.if_valid) begin ivc = c; bus.if_req = 1'b0; end
      bus.mem_rdata = bus.mem_addr ^ K;
    end
    check("sim_dm_cycle", dvc, 3);
    check("sim_if_cycle", ivc, 5);
    check("sim_nreq", nreq, 2);
    check("sim_dm_rdata", bus.dm_rdata, 32'h100 ^ K);
    check("sim_if_rdata", bus.if_rdata, 32'h20 ^ K);

    // store with 3 wait states
    bus.dm_req    = 1'b1;
    bus.dm_we     = 1'b1;
    bus.dm_be     = 4'b0011;
    bus.dm_addr   = 32'h40;
    bus.dm_wdata  = 32'hDEAD_BEEF;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h1234_5678;
    ns = 0; dvc = 0;
    for (int c = 2; c <= 10; c++) begin
      tick();
      if (bus.mem_req) begin
        ns++;
        check("st_addr", bus.mem_addr, 32'h40);
        check("st_ctl", {bus.mem_we, bus.mem_be, bus.mem_wdata},
              {1'b1, 4'b0011, 32'hDEAD_BEEF});
      end
      if (bus.dm_valid) begin
        dvc = c;
        bus.dm_req = 1'b0;
        check("st_err", bus.err, 1'b0);
      end
      bus.mem_ready = bus.mem_req && (ns == 4);
    end
    check("st_serve_cycles", ns, 4);
    check("st_valid_cycle", dvc, 6);
    check("st_rdata_kept", bus.dm_rdata, 32'h100 ^ K);

    // watchdog abort, then a late mem_ready
    bus.dm_req    = 1'b1;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = 32'h80;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'hBAD0_BAD0;
    nm = 0; dvc = 0; nv = 0; ne = 0; errv = 1'b0; rd = '1;
    for (int c = 2; c <= 14; c++) begin
      tick();
      if (bus.mem_req) nm++;
      if (bus.err) ne++;
      if (bus.dm_valid) begin
        nv++; dvc = c; errv = bus.err; rd = bus.dm_rdata;
        bus.dm_req = 1'b0;
      end
      if (dvc != 0) bus.mem_ready = 1'b1;
    end
    check("to_req_cycles", nm, TO);
    check("to_valid_cycle", dvc, 6);
    check("to_err", errv, 1'b1);
    check("to_rdata", rd, 0);
    check("to_one_valid", nv, 1);
    check("to_one_err", ne, 1);

    // asynchronous reset in the middle of a fetch
    bus.mem_ready = 1'b0;
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h30;
    tick();
    check("ra_req", bus.mem_req, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("ra_async_drop", bus.mem_req, 1'b0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0013_0313;
    tick();
    tick();
    check("ra_held", {bus.mem_req, bus.if_valid, bus.if_rdata}, 0);
    #3 reset = 1'b1;
    nv = 0; first = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (bus.if_valid) begin
        nv++; first = c;
        bus.if_req = 1'b0;
      end
    end
    check("ra_one_valid", nv, 1);
    check("ra_latency", first, 2);
    check("ra_rdata", bus.if_rdata, 32'h0013_0313);

    // random traffic against the reference model
    do_reset();
    for (int i = 0; i < 16; i++) mm[i] = $urandom;
    ip = 0; dp = 0; busy = 0; waits = 0; who_d = 0; hang = 0;
    xi_v = 0; xd_v = 0; x_err = 0; x_mreq = 0;
    x_ir = '0; x_dr = '0;
    g_addr = '0; g_wd = '0; g_we = 0; g_be = '0;
`ifdef MEM_ARB_RR_EN
    last_d = 0;
`endif
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      check("r_mem_req", bus.mem_req, x_mreq);
      check("r_valid", {bus.if_valid, bus.dm_valid, bus.err},
            {xi_v, xd_v, x_err});
      check("r_if_rdata", bus.if_rdata, x_ir);
      check("r_dm_rdata", bus.dm_rdata, x_dr);
      if (x_mreq) begin
        check("r_mem_addr", bus.mem_addr, g_addr);
        check("r_mem_ctl", {bus.mem_we, bus.mem_be}, {g_we, g_be});
        if (g_we) check("r_mem_wdata", bus.mem_wdata, g_wd);
      end

      // requesters: release on completion, maybe issue anew
      if (xi_v) ip = 0;
      if (xd_v) dp = 0;
      if (!ip && $urandom_range(3) == 0) begin
        ip = 1;
        ia = 32'($urandom_range(15)) << 2;
      end
      if (!dp && $urandom_range(3) == 0) begin
        dp  = 1;
        da  = 32'($urandom_range(15)) << 2;
        dwe = 1'($urandom_range(1));
        dbe = 4'($urandom_range(1, 15));
        dwd = $urandom;
      end
      bus.if_req   = ip;
      bus.if_addr  = ip ? ia : $urandom;
      bus.dm_req   = dp;
      bus.dm_we    = dp ? dwe : 1'($urandom_range(1));
      bus.dm_be    = dp ? dbe : 4'($urandom_range(15));
      bus.dm_addr  = dp ? da : $urandom;
      bus.dm_wdata = dp ? dwd : $urandom;

      // memory: random waits, occasional hang, stray readies
      rdy = x_mreq ? (!hang && $urandom_range(1) == 1)
                   : ($urandom_range(1) == 1);
      bus.mem_ready = rdy;
      bus.mem_rdata = x_mreq ? mm[g_addr[5:2]] : $urandom;
      #1;
      check("r_stall", {bus.stall_if, bus.stall_mem},
            {ip & ~xi_v, dp & ~xd_v});

      // expectations for the next cycle
      ni = 0; nd = 0; nerr = 0;
      if (busy) begin
        if (rdy) begin
          if (who_d) begin
            nd = 1;
            if (!g_we) x_dr = mm[g_addr[5:2]];
            else
              for (int b = 0; b < 4; b++)
                if (g_be[b]) mm[g_addr[5:2]][8*b +: 8] = g_wd[8*b +: 8];
          end else begin
            ni = 1;
            x_ir = mm[g_addr[5:2]];
          end
          busy = 0;
        end else begin
          waits++;
          if (waits == TO) begin
            nerr = 1;
            if (who_d) begin nd = 1; x_dr = '0; end
            else begin ni = 1; x_ir = '0; end
            busy = 0;
          end
        end
      end else begin
        ei = ip & ~xi_v;
        ed = dp & ~xd_v;
        if (ei || ed) begin
`ifdef MEM_ARB_RR_EN
          pick_d = ed & (~ei | ~last_d);
          last_d = pick_d;
`else
          pick_d = ed;
`endif
          busy  = 1;
          who_d = pick_d;
          waits = 0;
          hang  = ($urandom_range(9) == 0);
          if (pick_d) begin
            g_addr = da; g_we = dwe; g_be = dbe; g_wd = dwd;
          end else begin
            g_addr = ia; g_we = 0; g_be = 4'hf; g_wd = '0;
          end
        end
      end
      x_mreq = busy;
      xi_v   = ni;
      xd_v   = nd;
      x_err  = nerr;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one unified single-ported memory between the RV32I core's fetch stage (PCF/InstrF) and memory stage (ALUResultM/WriteDataM/readDataM). A small FSM grants one requester at a time, holds the memory request until the memory acknowledges, and returns read data. It raises per-stage stall signals that the hazard unit ORs into its stall/flush logic. Fixed data-over-fetch priority by default; a watchdog aborts hung accesses.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data width
TIMEOUT_CYCLES, 64, wait cycles with mem_ready low before abort; 0 disables the watchdog
CNT_W, $clog2(TIMEOUT_CYCLES+1) (minimum 1), watchdog counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
if_req  in  1  fetch request, held until if_valid
if_addr  in  ADDR_W  fetch address (PCF)
if_rdata  out  DATA_W  fetched instruction
if_valid  out  1  one-cycle fetch completion pulse
dm_req  in  1  data request, held until dm_valid
dm_we  in  1  1 = store, 0 = load
dm_be  in  DATA_W/8  store byte enables
dm_addr  in  ADDR_W  data address (ALUResultM)
dm_wdata  in  DATA_W  store data (WriteDataM)
dm_rdata  out  DATA_W  load data
dm_valid  out  1  one-cycle data completion pulse
stall_if  out  1  fetch request pending, not complete
stall_mem  out  1  data request pending, not complete
err  out  1  one-cycle pulse alongside the valid of an aborted access
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_be  out  DATA_W/8  memory byte enables
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1
mem_ready  in  1  memory completion, accepted only while mem_req=1

Behaviour:
- Reset: state IDLE; all outputs 0, including rdata registers, valids, err, mem_* and the watchdog counter. Asynchronous: mem_req drops immediately, even mid-access. Any in-flight access is discarded and produces no valid.
- FSM states are IDLE, SERVE_D and SERVE_I.
- IDLE: if dm_req=1, go to SERVE_D. Otherwise, if if_req=1, go to SERVE_I. Otherwise stay in IDLE.
  - At grant, mem_addr, mem_we, mem_be and mem_wdata are registered from the granted requester. For fetch, mem_we=0 and mem_be is all ones.
  - mem_req=1 from the first SERVE cycle.
- SERVE_x: mem_req and the latched mem_* fields are held stable. Requester inputs are ignored.
  - On a cycle with mem_ready=1, next state is IDLE and mem_req=0 next cycle. In that next cycle x_valid=1 for exactly one cycle.
  - A fetch or data load captures mem_rdata into x_rdata. A store leaves dm_rdata unchanged.
  - x_rdata holds its value until the next completion for that requester.
- Minimum access latency is grant cycle + 1 SERVE cycle + 1 valid cycle, i.e. 3 cycles from req to valid with zero-wait memory.
- Arbitration in the valid cycle ignores the req of the requester whose valid is high, so no duplicate access occurs. The other requester may be granted in that same IDLE cycle (back-to-back, no extra bubble).
- stall_if = if_req & ~if_valid; stall_mem = dm_req & ~dm_valid. Both are combinational from registered state.
- Watchdog (TIMEOUT_CYCLES>0):
  - The counter clears at grant and increments each SERVE cycle with mem_ready=0.
  - When it reaches TIMEOUT_CYCLES: mem_req drops, state goes to IDLE, and x_valid=1 with err=1 next cycle. x_rdata is set to 0.
  - A late mem_ready arriving while mem_req=0 is ignored.
- Simultaneous mem_ready and timeout in the same cycle: mem_ready wins and err stays 0.

Optional Feature:
MEM_ARB_RR_EN. When defined, a last_grant register (reset to fetch) is added. When both requests arrive in IDLE, the grant goes to the requester not served last, and last_grant updates on every grant. When undefined, data always wins over fetch; this is the default and matches in-order pipeline semantics.

Test Plan:
- Zero-wait fetch only: if_req=1, if_addr=0x0000_0010, mem_ready=1 in the first SERVE cycle, mem_rdata=0x0051_0513 -> mem_addr=0x10 and mem_we=0; if_valid pulses on cycle 3; if_rdata=0x0051_0513; stall_if=1 for cycles 1-2.
- Simultaneous requests with the macro undefined: if_req=dm_req=1, dm_we=0, dm_addr=0x100 -> data served first (dm_valid, then fetch granted in the dm_valid cycle), then if_valid; memory sees exactly 2 requests.
- Store with 3 wait states: dm_we=1, dm_be=4'b0011, dm_wdata=0xDEAD_BEEF, mem_ready after 3 low cycles -> mem_* stable for 4 SERVE cycles; dm_valid on cycle 6; dm_rdata unchanged.
- Timeout with TIMEOUT_CYCLES=4 and mem_ready stuck at 0 -> mem_req drops after 4 wait cycles; dm_valid=err=1 for one cycle; dm_rdata=0; a late mem_ready is ignored.
- Reset mid-access: reset=0 during SERVE_I -> mem_req=0 asynchronously; no if_valid; after release, a fresh if_req is served normally.
- With MEM_ARB_RR_EN defined, both requests held continuously -> grants alternate D, I, D, I, starting with data.
